// File: rtl/seven_seg_pkg.sv
// Shared glyphs, mode enum, status words and BCD sizing helper
// for the seven-segment controller. Glyphs are active-low, bit0=a(top), bit6=g(middle).
package seven_seg_pkg;

    localparam logic [6:0] GLY_0    = ~7'h3F;
    localparam logic [6:0] GLY_1    = ~7'h06;
    localparam logic [6:0] GLY_2    = ~7'h5B;
    localparam logic [6:0] GLY_3    = ~7'h4F;
    localparam logic [6:0] GLY_4    = ~7'h66;
    localparam logic [6:0] GLY_5    = ~7'h6D;
    localparam logic [6:0] GLY_6    = ~7'h7D;
    localparam logic [6:0] GLY_7    = ~7'h07;
    localparam logic [6:0] GLY_8    = ~7'h7F;
    localparam logic [6:0] GLY_9    = ~7'h6F;
    localparam logic [6:0] GLY_A    = ~7'h77;
    localparam logic [6:0] GLY_C    = ~7'h39;
    localparam logic [6:0] GLY_D    = ~7'h5E;
    localparam logic [6:0] GLY_E    = ~7'h79;
    localparam logic [6:0] GLY_L    = ~7'h38;
    localparam logic [6:0] GLY_N    = ~7'h37;
    localparam logic [6:0] GLY_P    = ~7'h73;
    localparam logic [6:0] GLY_R    = ~7'h50;
    localparam logic [6:0] GLY_S    = ~7'h6D;
    localparam logic [6:0] GLY_U    = ~7'h3E;
    localparam logic [6:0] GLY_Y    = ~7'h6E;
    localparam logic [6:0] GLY_DASH = ~7'h40;
    localparam logic [6:0] GLY_DARK = 7'h7F;

    typedef enum logic [2:0] {
        MODE_1N1  = 3'd0,
        MODE_IDLE = 3'd1,
        MODE_PLAY = 3'd2,
        MODE_REC  = 3'd3,
        MODE_PAUS = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } b2b_state_e;

    // Leftmost character in the top 7 bits; "I" reuses the digit-1 glyph.
    localparam logic [27:0] STATUS_TBL [0:4] = '{
        {GLY_1, GLY_N, GLY_1, GLY_DARK},
        {GLY_1, GLY_D, GLY_L, GLY_E},
        {GLY_P, GLY_L, GLY_A, GLY_Y},
        {GLY_R, GLY_E, GLY_C, GLY_DARK},
        {GLY_P, GLY_A, GLY_U, GLY_S}
    };

    // Decimal digits needed for a w-bit value: floor(w*log10(2))+1.
    function automatic int bcd_digits(int w);
        return ((w * 1233) >>> 12) + 1;
    endfunction

    function automatic logic [27:0] status_word(logic [2:0] m);
        logic [27:0] w;
        w = {4{GLY_DARK}};
        if (m <= MODE_PAUS) w = STATUS_TBL[m];
        return w;
    endfunction

    function automatic logic [6:0] digit_glyph(logic [3:0] d);
        logic [6:0] g;
        unique case (d)
            4'd0:    g = GLY_0;
            4'd1:    g = GLY_1;
            4'd2:    g = GLY_2;
            4'd3:    g = GLY_3;
            4'd4:    g = GLY_4;
            4'd5:    g = GLY_5;
            4'd6:    g = GLY_6;
            4'd7:    g = GLY_7;
            4'd8:    g = GLY_8;
            4'd9:    g = GLY_9;
            default: g = GLY_DARK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
// Ports: i_clk, i_rst_n, start (capture value), value, busy (SHIFT), done (1-cycle), bcd (held result).
module bin2bcd_seq
    import seven_seg_pkg::*;
#(
    parameter int VAL_W = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            start,
    input  logic [VAL_W-1:0]                value,
    output logic                            busy,
    output logic                            done,
    output logic [4*bcd_digits(VAL_W)-1:0]  bcd
);

    localparam int BD = bcd_digits(VAL_W);
    localparam int CW = $clog2(VAL_W + 1);

    b2b_state_e         state_q, state_d;
    logic [VAL_W-1:0]   sh_q, sh_d;
    logic [4*BD-1:0]    acc_q, acc_d;
    logic [4*BD-1:0]    acc_adj;
    logic [4*BD-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < BD; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_d    = value;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d = {acc_adj[4*BD-2:0], sh_q[VAL_W-1]};
                sh_d  = sh_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(VAL_W - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                bcd_d   = acc_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign bcd  = bcd_q;

endmodule

// File: rtl/seven_seg_ctrl.sv
// Seven-segment controller: 4-digit status word on top, converted decimal value below.
// Ports: i_clk, i_rst_n, i_value/i_load (conversion), i_mode, i_blink; o_busy, o_done, o_seg.
// Optional SEG_BLINK_EN: free-running blink counter that darkens the numeric field.
module seven_seg_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int VAL_W      = 16,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [VAL_W-1:0]        i_value,
    input  logic                    i_load,
    input  logic [2:0]              i_mode,
    input  logic                    i_blink,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [7*NUM_DIGITS-1:0] o_seg
);

    localparam int ND = NUM_DIGITS - 4;
    localparam int BD = bcd_digits(VAL_W);
    localparam int MD = (BD > ND) ? BD : ND;

    logic                    busy, done;
    logic [4*BD-1:0]         bcd;
    logic [4*MD-1:0]         bcd_ext;
    logic                    ovf;
    logic                    blank;
    logic                    lead;
    logic [3:0]              dig;
    logic                    valid_q;
    logic [7*NUM_DIGITS-1:0] seg_q, seg_d;

    bin2bcd_seq #(
        .VAL_W (VAL_W)
    ) u_b2b (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .start   (i_load),
        .value   (i_value),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd)
    );

`ifdef SEG_BLINK_EN
    localparam int BCW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
    logic           blink_ph_q, blink_ph_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_ph_d  = blink_ph_q;
        if (blink_cnt_q == BCW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    assign blank = i_blink & blink_ph_q;
`else
    // Blinking is compiled out; the request is accepted but has no effect.
    assign blank = i_blink & 1'b0;
`endif

    // Narrow converters are zero-extended so every numeric digit has a source.
    assign bcd_ext = (4*MD)'(bcd);
    assign ovf     = |(bcd_ext >> (4*ND));

    always_comb begin
        seg_d            = '1;
        lead             = 1'b0;
        dig              = '0;
        seg_d[7*ND +: 28] = status_word(i_mode);
        if (valid_q && !blank) begin
            for (int k = ND - 1; k >= 0; k--) begin
                dig = bcd_ext[4*k +: 4];
                // Light from the first nonzero digit down; digit 0 always lit.
                if (dig != 4'd0 || k == 0) lead = 1'b1;
                if (ovf)       seg_d[7*k +: 7] = GLY_DASH;
                else if (lead) seg_d[7*k +: 7] = digit_glyph(dig);
            end
        end
    end

    // The engine's result only changes in DONE, so the display never shows partial BCD.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            seg_q   <= '1;
            valid_q <= 1'b0;
        end else begin
            seg_q <= seg_d;
            if (done) valid_q <= 1'b1;
        end
    end

    assign o_busy = busy;
    assign o_done = done;
    assign o_seg  = seg_q;

endmodule

// File: tb/tb_seven_seg_ctrl.sv
// Self-checking bench for seven_seg_ctrl: vector table, hand sequences, random vs. model.
// Define SEG_BLINK_EN to also exercise the blink path (BLINK_DIV=4).
module tb_seven_seg_ctrl;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [15:0] i_value;
    logic        i_load;
    logic [2:0]  i_mode;
    logic        i_blink;
    logic        o_busy;
    logic        o_done;
    logic [55:0] o_seg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seven_seg_ctrl #(
        .NUM_DIGITS (8),
        .VAL_W      (16),
        .BLINK_DIV  (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_value (i_value),
        .i_load  (i_load),
        .i_mode  (i_mode),
        .i_blink (i_blink),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_seg   (o_seg)
    );

    typedef struct packed {
        logic [15:0] value;
        logic [2:0]  mode;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Segment shapes, active-high gfedcba, inverted for the active-low display.
    function automatic logic [6:0] glyph(logic [7:0] c);
        logic [6:0] g;
        case (c)
            "0": g = 7'h3F; "1": g = 7'h06; "2": g = 7'h5B; "3": g = 7'h4F;
            "4": g = 7'h66; "5": g = 7'h6D; "6": g = 7'h7D; "7": g = 7'h07;
            "8": g = 7'h7F; "9": g = 7'h6F; "A": g = 7'h77; "C": g = 7'h39;
            "D": g = 7'h5E; "E": g = 7'h79; "I": g = 7'h06; "L": g = 7'h38;
            "N": g = 7'h37; "P": g = 7'h73; "R": g = 7'h50; "S": g = 7'h6D;
            "U": g = 7'h3E; "Y": g = 7'h6E; "-": g = 7'h40;
            default: g = 7'h00;
        endcase
        return ~g;
    endfunction

    // 8 characters, leftmost in the top byte, to the expected 56-bit o_seg.
    function automatic logic [55:0] segs(logic [63:0] s);
        logic [55:0] r;
        for (int i = 0; i < 8; i++) r[7*i +: 7] = glyph(s[8*i +: 8]);
        return r;
    endfunction

    function automatic logic [63:0] str2bits(string s);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*(7-i) +: 8] = s[i];
        return r;
    endfunction

    // Reference: status text by mode, number right-aligned without leading zeros.
    function automatic logic [55:0] model(int mode, bit valid, int v, bit dark);
        string st;
        string nm;
        case (mode)
            0: st = "1N1 ";
            1: st = "IDLE";
            2: st = "PLAY";
            3: st = "REC ";
            4: st = "PAUS";
            default: st = "    ";
        endcase
        nm = "    ";
        if (valid && !dark) begin
            if (v > 9999) nm = "----";
            else          nm = $sformatf("%4d", v);
        end
        return segs(str2bits({st, nm}));
    endfunction

    task automatic convert(input int v, input int ld2_at, input int v2,
                           output int nbusy, output int ndone, output int done_at);
        i_value = 16'(v);
        i_load  = 1'b1;
        nbusy   = 0;
        ndone   = 0;
        done_at = -1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            i_load = 1'b0;
            if (o_busy) nbusy++;
            if (o_done) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            if (c == ld2_at) begin
                i_value = 16'(v2);
                i_load  = 1'b1;
            end
        end
        i_load = 1'b0;
    endtask

    initial begin
        int nb, nd, da, ndn;
        logic [55:0] e, held;
        bit prev_dark, cur_dark;
        int last_chg, nchg;

        tbl[0] = '{16'd1234,  3'd1, "IDLE1234"};
        tbl[1] = '{16'd7,     3'd0, "1N1    7"};
        tbl[2] = '{16'd10000, 3'd3, "REC ----"};
        tbl[3] = '{16'd0,     3'd4, "PAUS   0"};
        tbl[4] = '{16'd9999,  3'd2, "PLAY9999"};
        tbl[5] = '{16'd65535, 3'd5, "    ----"};
        tbl[6] = '{16'd100,   3'd7, "     100"};
        tbl[7] = '{16'd3050,  3'd2, "PLAY3050"};

        i_rst_n = 1'b0;
        i_value = '0;
        i_load  = 1'b0;
        i_mode  = 3'd0;
        i_blink = 1'b0;
        #12;
        chk("reset_seg", 64'(o_seg), {8'h0, 56'hFF_FFFF_FFFF_FFFF});
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_done", 64'(o_done), 64'd0);
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("status_before_load", 64'(o_seg), 64'(segs("1N1     ")));

        for (int i = 0; i < 8; i++) begin
            i_mode = tbl[i].mode;
            convert(int'(tbl[i].value), 0, 0, nb, nd, da);
            chk($sformatf("tbl%0d_busy", i), 64'(nb), 64'd16);
            chk($sformatf("tbl%0d_done_at", i), 64'(da), 64'd17);
            chk($sformatf("tbl%0d_ndone", i), 64'(nd), 64'd1);
            chk($sformatf("tbl%0d_seg", i), 64'(o_seg), 64'(segs(tbl[i].exp)));
        end

        i_mode = 3'd2;
        convert(42, 3, 99, nb, nd, da);
        chk("reload_busy", 64'(nb), 64'd16);
        chk("reload_ndone", 64'(nd), 64'd1);
        chk("reload_seg", 64'(o_seg), 64'(segs("PLAY  42")));

        convert(123, 18, 4567, nb, nd, da);
        chk("b2b_first_seg", 64'(o_seg), 64'(segs("PLAY 123")));
        chk("b2b_accepted", 64'(o_busy), 64'd1);
        ndn = 0;
        for (int c = 0; c < 18; c++) begin
            tick();
            if (o_done) ndn++;
        end
        chk("b2b_ndone", 64'(ndn), 64'd1);
        chk("b2b_second_seg", 64'(o_seg), 64'(segs("PLAY4567")));

        i_mode = 3'd4;
        #1;
        chk("mode_registered", 64'(o_seg), 64'(segs("PLAY4567")));
        tick();
        chk("mode_one_cycle", 64'(o_seg), 64'(segs("PAUS4567")));

        e = model(4, 1'b1, 4567, 1'b0);
        i_blink = 1'b1;
`ifdef SEG_BLINK_EN
        prev_dark = 1'b0;
        last_chg  = -1;
        nchg      = 0;
        for (int t = 0; t < 28; t++) begin
            tick();
            chk("blink_status", 64'(o_seg[55:28]), 64'(e[55:28]));
            cur_dark = (o_seg[27:0] == '1);
            if (!cur_dark) chk("blink_lit", 64'(o_seg[27:0]), 64'(e[27:0]));
            if (t > 0 && cur_dark != prev_dark) begin
                if (last_chg >= 0) chk("blink_period", 64'(t - last_chg), 64'd4);
                last_chg = t;
                nchg++;
            end
            prev_dark = cur_dark;
        end
        chk("blink_toggles", 64'(nchg >= 5), 64'd1);
`else
        prev_dark = 1'b0;
        last_chg  = 0;
        nchg      = 0;
        cur_dark  = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            chk("no_blink", 64'(o_seg), 64'(e));
        end
`endif
        i_blink = 1'b0;
        tick();

        for (int r = 0; r < 16; r++) begin
            int v, m;
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                             : int'($urandom_range(0, 12000));
            m = int'($urandom_range(0, 7));
            i_mode = 3'(m);
            convert(v, 0, 0, nb, nd, da);
            chk($sformatf("rand%0d_ndone v=%0d", r, v), 64'(nd), 64'd1);
            chk($sformatf("rand%0d_seg v=%0d m=%0d", r, v, m), 64'(o_seg),
                64'(model(m, 1'b1, v, 1'b0)));
        end

        i_mode  = 3'd1;
        i_value = 16'd500;
        i_load  = 1'b1;
        tick();
        i_load = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("midreset_in_shift", 64'(o_busy), 64'd1);
        i_rst_n = 1'b0;
        #1;
        chk("midreset_seg", 64'(o_seg), {8'h0, 56'hFF_FFFF_FFFF_FFFF});
        chk("midreset_busy", 64'(o_busy), 64'd0);
        chk("midreset_done", 64'(o_done), 64'd0);
        i_mode = 3'd2;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("post_reset_play", 64'(o_seg), 64'(segs("PLAY    ")));
        held = o_seg;
        ndn  = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (o_done) ndn++;
            if (o_seg !== held) ndn += 100;
        end
        chk("post_reset_quiet", 64'(ndn), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_ctrl.md
SEVEN_SEG_CTRL -- requirements
Module: seven_seg_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, total digits driven; legal range 5..8.
REQ-002 SHALL have parameter VAL_W, default 16, binary value width; legal range 4..27.
REQ-003 SHALL have parameter BLINK_DIV, default 25_000_000, clock cycles per blink half-period; minimum 2.
REQ-004 SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_value  input  VAL_W  unsigned value to display.
REQ-007 SHALL have port i_load  input  1  one-cycle strobe; starts conversion of i_value.
REQ-008 SHALL have port i_mode  input  3  status word select.
REQ-009 SHALL have port i_blink  input  1  numeric-field blink request.
REQ-010 SHALL have port o_busy  output  1  conversion in progress.
REQ-011 SHALL have port o_done  output  1  one-cycle pulse on conversion completion.
REQ-012 SHALL have port o_seg  output  7*NUM_DIGITS  active-low segments; digit k at bits [7k+6:7k]; bit order g..a (bit0 = top, bit6 = middle).

Function
REQ-013 SHALL split the display into a status field (top 4 digits) and a numeric field (lower ND = NUM_DIGITS-4 digits).
REQ-014 SHALL map i_mode to status words: 0 "1N1 ", 1 "IDLE", 2 "PLAY", 3 "REC ", 4 "PAUS", 5..7 all dark; leftmost character on digit NUM_DIGITS-1.
REQ-015 SHALL convert binary to BCD with a sequential shift-add-3 engine, one bit per cycle; states IDLE, SHIFT, DONE.
REQ-016 SHALL in IDLE capture i_value on a cycle where i_load=1, enter SHIFT, and assert o_busy on the next cycle.
REQ-017 SHALL remain in SHIFT exactly VAL_W cycles, then enter DONE for one cycle, asserting o_done and updating the stored result; then return to IDLE with o_busy=0.
REQ-018 SHALL ignore i_load while o_busy=1; no queuing, and the captured value is not disturbed.
REQ-019 SHALL accept i_load in the cycle immediately after DONE, giving back-to-back conversions every VAL_W+2 cycles.
REQ-020 SHALL hold the previous numeric result on o_seg throughout a conversion; no partial BCD is ever displayed.
REQ-021 SHALL, when the result exceeds 10^ND-1, show the dash glyph (middle segment only) on every numeric digit.
REQ-022 SHALL blank leading zeros: digits above the most-significant nonzero digit are dark; digit 0 is always lit, so value 0 shows "0".
REQ-023 SHALL register o_seg; a change of i_mode, i_blink or the stored result appears on o_seg one cycle later.
REQ-024 SHALL keep the numeric field dark until the first conversion completes after reset.

Reset
REQ-025 SHALL, on i_rst_n low, immediately and asynchronously force: state IDLE, o_busy=0, o_done=0, all o_seg bits 1, stored result 0 with valid flag clear, blink counter 0, blink phase 0.
REQ-026 SHALL abort a conversion in progress when reset is asserted mid-conversion; no o_done pulse follows, and the display stays dark.

Configuration
REQ-027 SHALL, with SEG_BLINK_EN defined, run a free counter wrapping at BLINK_DIV-1 and toggle the blink phase on wrap; while i_blink=1 and phase=1, the numeric field is dark and the status field is unaffected.
REQ-028 SHALL, without SEG_BLINK_EN, exclude the counter, ignore i_blink, and never blank the numeric field for blinking.

Structure
REQ-029 SHALL place glyph constants (digits 0-9, letters A C E L N P R S U Y, dash, dark), the mode enum and the 5-entry status word table in package seven_seg_pkg.
REQ-030 SHALL implement the conversion engine as sub-module bin2bcd_seq (parameter VAL_W, ports i_clk, i_rst_n, start, value, busy, done, bcd).

Verification
REQ-031 SHALL cover: defaults; i_value=1234 with i_load pulse -> o_busy 16 cycles, o_done at cycle 17, then digits 3..0 show 1,2,3,4.
REQ-032 SHALL cover: i_value=7 -> digit0 shows 7; digits 3..1 dark.
REQ-033 SHALL cover: i_value=10000 -> digits 3..0 all show dash; i_value=0 -> digit0 shows "0".
REQ-034 SHALL cover: load 42, then load 99 three cycles later -> second load ignored, result shows 42, exactly one o_done pulse.
REQ-035 SHALL cover: reset asserted at SHIFT cycle 5 -> o_seg all 1s at once, o_busy=0, no o_done; i_mode=2 then shows "PLAY" one cycle after release.
REQ-036 SHALL cover: SEG_BLINK_EN with BLINK_DIV=4 and i_blink=1 -> numeric field alternates lit/dark every 4 cycles while the status field stays constant.
